tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Frame-level controller for the tile painter. On a frame request it steps the painter across the screen tile by tile in row-major order, with x-offsets 0,20,…,300 and y-offsets 0,45,90,135. For each tile it runs the painter, hands the finished tile BRAM to the framebuffer copy-out logic, and has the painter wipe the tile BRAM before the next tile. It sits between the frame/triangle-setup logic and the painter, and owns the painter's `active`, `wipe`, offset and triangle-count inputs.

## Interface
- `MAX_TRIANGLES`, 256: triangle BRAM depth; count width is `$clog2(MAX_TRIANGLES)`.
- `TILES_X`, 16: tiles per row.
- `TILES_Y`, 4: tile rows.
- `TILE_W`, 20: tile width in pixels.
- `TILE_H`, 45: tile height in pixels.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: single-cycle request to render a frame. Ignored unless `busy`=0.
- `num_triangles` in `$clog2(MAX_TRIANGLES)`: triangle count, captured on an accepted `frame_start`.
- `painter_done` in 1: painter `done`, level signal.
- `flush_done` in 1: single-cycle pulse; tile BRAM copy-out has completed.
- `painter_active` out 1: painter `active`.
- `painter_wipe` out 1: painter `wipe`.
- `painter_x_offset` out 9: current tile x-offset.
- `painter_y_offset` out 8: current tile y-offset.
- `painter_num_triangles` out `$clog2(MAX_TRIANGLES)`: captured triangle count.
- `flush_start` out 1: single-cycle pulse; copy the current tile to the framebuffer at the current offsets.
- `tile_index` out 6: current tile number, `ty*TILES_X+tx`.
- `busy` out 1: high from an accepted `frame_start` until `frame_done`.
- `frame_done` out 1: single-cycle pulse when the last tile has been wiped.

## Operation
- All outputs are registered.
- Reset values: every output is 0; state is IDLE; `tx`=`ty`=0; `prewipe`=0.
- `tx` and `ty` are internal tile counters. Offsets are maintained by accumulation (`+TILE_W` or `+TILE_H`), with no multiplier.

State machine:
- **IDLE**
  - On `frame_start`: capture `num_triangles`, clear `tx`, `ty` and both offsets, set `prewipe`=1 and `busy`=1, go to WIPE_LOW.
- **WIPE_LOW**
  - Outputs: `painter_active`=1, `painter_wipe`=1.
  - Advance to WIPE_HIGH when `painter_done`=0. This absorbs the painter's stale `done` from its DONE state.
- **WIPE_HIGH**
  - Outputs: `painter_active`=1, `painter_wipe`=0.
  - Wait for `painter_done`=1, which is the painter's WIPEDONE.
  - If `prewipe`=1: clear it and go to RELEASE. Otherwise go to ADVANCE.
- **RELEASE**
  - Output: `painter_active`=0 for exactly 2 cycles. This guarantees the painter returns to RST and `done` is seen low.
  - Then go to PAINT.
- **PAINT**
  - Output: `painter_active`=1.
  - Go to FLUSH_REQ when `painter_done`=1.
- **FLUSH_REQ**
  - Outputs: `flush_start`=1 for one cycle; `painter_active` stays 1, so the painter holds in DONE.
  - Go to FLUSH_WAIT.
- **FLUSH_WAIT**
  - Wait for `flush_done`. `flush_done` is sampled only in this state.
  - Then go to WIPE_LOW.
- **ADVANCE**
  - `painter_active`=1.
  - If `tx`<`TILES_X`-1: increment `tx`, add `TILE_W` to the x-offset, go to RELEASE.
  - Otherwise, if `ty`<`TILES_Y`-1: set `tx`=0, x-offset=0, increment `ty`, add `TILE_H` to the y-offset, go to RELEASE.
  - Otherwise (last tile): pulse `frame_done`, clear `busy`, drop `painter_active`, go to IDLE.

Boundary conditions:
- `num_triangles`=0 is legal; the painter reports done almost immediately.
- Offsets and the captured triangle count are stable from RELEASE through ADVANCE. They change only in ADVANCE or IDLE.
- `frame_start` while `busy`=1 has no effect; no queueing.
- `rst` asserted in any state returns all outputs to reset values immediately; any painter or flush operation in progress is abandoned.

## Timing
- Frame accept: `busy` and `painter_active` rise on the edge after `frame_start` is sampled.
- `painter_wipe` is high throughout WIPE_LOW and falls in the cycle `painter_done`=0 is observed.
- RELEASE is exactly 2 cycles of `painter_active`=0. It follows the pre-wipe and every tile's WIPE_HIGH/ADVANCE.
- FLUSH_REQ: `flush_start` is high for exactly 1 cycle, 1 cycle after `painter_done` is seen in PAINT.
- `flush_done` arriving in the same cycle as `flush_start` is ignored; the bench must not rely on it.
- Tile overhead, excluding painter and flush time, is a fixed count. PAINT→FLUSH_REQ→FLUSH_WAIT takes 2 cycles minimum. WIPE_LOW ≥1 cycle; WIPE_HIGH ≥1 cycle; ADVANCE 1 cycle; RELEASE 2 cycles.
- `frame_done`: single-cycle pulse, asserted in the same cycle `busy` falls.

## Test plan
- **Reset:** assert `rst` mid-cycle with no clock edge → all outputs 0 immediately; after release, `busy`=0.
- **Empty frame:** behavioural painter model, `num_triangles`=0, `flush_done` 3 cycles after each `flush_start`.
  - Required: exactly 64 `flush_start` pulses, offsets (0,0),(20,0),…,(300,0),(0,45),…,(300,135) in order.
  - Required: 65 wipe sequences including the pre-wipe, then one `frame_done` pulse.
- **Flush stall:** hold `flush_done` off for 500 cycles → `painter_wipe` stays 0 and offsets are unchanged until `flush_done`; wipe starts on the next cycle.
- **Busy rejection:** `frame_start` pulsed during tile 10 → no restart; `tile_index` continues 10→11; exactly one `frame_done`.
- **Count capture:** `num_triangles`=37 at `frame_start`, changed to 5 mid-frame → `painter_num_triangles`=37 for the whole frame.
- **Reset mid-PAINT:** `rst` at tile 20 → `painter_active`=0, `busy`=0. A new `frame_start` restarts with the pre-wipe and offsets (0,0).

Source files
------------

// File: rtl/tile_scheduler.sv
// Frame-level tile sequencer: walks the painter across the screen in row-major
// order, interleaving paint, framebuffer copy-out and tile BRAM wipe per tile.
module tile_scheduler #(
  parameter int unsigned MAX_TRIANGLES = 256,
  parameter int unsigned TILES_X       = 16,
  parameter int unsigned TILES_Y       = 4,
  parameter int unsigned TILE_W        = 20,
  parameter int unsigned TILE_H        = 45
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [$clog2(MAX_TRIANGLES)-1:0] num_triangles,
  input  logic                             painter_done,
  input  logic                             flush_done,
  output logic                             painter_active,
  output logic                             painter_wipe,
  output logic [8:0]                       painter_x_offset,
  output logic [7:0]                       painter_y_offset,
  output logic [$clog2(MAX_TRIANGLES)-1:0] painter_num_triangles,
  output logic                             flush_start,
  output logic [5:0]                       tile_index,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned CNT_W = $clog2(MAX_TRIANGLES);
  localparam int unsigned TX_W  = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int unsigned TY_W  = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
  localparam int unsigned XO_W  = 9;
  localparam int unsigned YO_W  = 8;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIPE_LOW,
    S_WIPE_HIGH,
    S_RELEASE,
    S_PAINT,
    S_FLUSH_REQ,
    S_FLUSH_WAIT,
    S_ADVANCE
  } state_t;

  state_t            state_q, state_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [TY_W-1:0]   ty_q, ty_d;
  logic              prewipe_q, prewipe_d;
  logic              rel_q, rel_d;
  logic              active_q, active_d;
  logic              wipe_q, wipe_d;
  logic [XO_W-1:0]   x_off_q, x_off_d;
  logic [YO_W-1:0]   y_off_q, y_off_d;
  logic [CNT_W-1:0]  ntri_q, ntri_d;
  logic              flush_q, flush_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;

  // State and all output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_q      <= '0;
      ty_q      <= '0;
      prewipe_q <= 1'b0;
      rel_q     <= 1'b0;
      active_q  <= 1'b0;
      wipe_q    <= 1'b0;
      x_off_q   <= '0;
      y_off_q   <= '0;
      ntri_q    <= '0;
      flush_q   <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      prewipe_q <= prewipe_d;
      rel_q     <= rel_d;
      active_q  <= active_d;
      wipe_q    <= wipe_d;
      x_off_q   <= x_off_d;
      y_off_q   <= y_off_d;
      ntri_q    <= ntri_d;
      flush_q   <= flush_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
    end
  end

  // Next state, counters and offsets; registered outputs decode the next state
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    prewipe_d = prewipe_q;
    rel_d     = 1'b0;
    x_off_d   = x_off_q;
    y_off_d   = y_off_q;
    ntri_d    = ntri_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    fdone_d   = 1'b0;
    active_d  = 1'b0;
    wipe_d    = 1'b0;
    flush_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          ntri_d    = num_triangles;
          tx_d      = '0;
          ty_d      = '0;
          x_off_d   = '0;
          y_off_d   = '0;
          idx_d     = '0;
          prewipe_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_WIPE_LOW;
        end
      end
      // Hold wipe until the painter's stale done from its DONE state clears
      S_WIPE_LOW: begin
        if (!painter_done) state_d = S_WIPE_HIGH;
      end
      S_WIPE_HIGH: begin
        if (painter_done) begin
          if (prewipe_q) begin
            prewipe_d = 1'b0;
            state_d   = S_RELEASE;
          end else begin
            state_d = S_ADVANCE;
          end
        end
      end
      // Two idle cycles so the painter falls back to RST with done low
      S_RELEASE: begin
        if (rel_q) state_d = S_PAINT;
        else       rel_d   = 1'b1;
      end
      S_PAINT: begin
        if (painter_done) state_d = S_FLUSH_REQ;
      end
      S_FLUSH_REQ: begin
        state_d = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (flush_done) state_d = S_WIPE_LOW;
      end
      S_ADVANCE: begin
        if (tx_q < TX_W'(TILES_X - 1)) begin
          tx_d    = tx_q + 1'b1;
          x_off_d = x_off_q + XO_W'(TILE_W);
          idx_d   = idx_q + 1'b1;
          state_d = S_RELEASE;
        end else if (ty_q < TY_W'(TILES_Y - 1)) begin
          tx_d    = '0;
          x_off_d = '0;
          ty_d    = ty_q + 1'b1;
          y_off_d = y_off_q + YO_W'(TILE_H);
          idx_d   = idx_q + 1'b1;
          state_d = S_RELEASE;
        end else begin
          fdone_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d != S_IDLE) && (state_d != S_RELEASE);
    wipe_d   = (state_d == S_WIPE_LOW);
    flush_d  = (state_d == S_FLUSH_REQ);
  end

  assign painter_active        = active_q;
  assign painter_wipe          = wipe_q;
  assign painter_x_offset      = x_off_q;
  assign painter_y_offset      = y_off_q;
  assign painter_num_triangles = ntri_q;
  assign flush_start           = flush_q;
  assign tile_index            = idx_q;
  assign busy                  = busy_q;
  assign frame_done            = fdone_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: cycle vectors for the first tile, then whole frames
// driven by a behavioural painter and copy-out responder.
module tb_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [7:0] num_triangles;
  logic       painter_done;
  logic       flush_done;
  logic       painter_active;
  logic       painter_wipe;
  logic [8:0] painter_x_offset;
  logic [7:0] painter_y_offset;
  logic [7:0] painter_num_triangles;
  logic       flush_start;
  logic [5:0] tile_index;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .frame_start          (frame_start),
    .num_triangles        (num_triangles),
    .painter_done         (painter_done),
    .flush_done           (flush_done),
    .painter_active       (painter_active),
    .painter_wipe         (painter_wipe),
    .painter_x_offset     (painter_x_offset),
    .painter_y_offset     (painter_y_offset),
    .painter_num_triangles(painter_num_triangles),
    .flush_start          (flush_start),
    .tile_index           (tile_index),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic use_model;
  logic v_pd, v_fd;
  logic m_done, fl_done;
  assign painter_done = use_model ? m_done  : v_pd;
  assign flush_done   = use_model ? fl_done : v_fd;

  // Behavioural painter: RST -> PAINT/WIPE -> DONE/WIPEDONE, reset by active=0
  localparam logic [2:0] P_RST = 3'd0, P_PAINT = 3'd1, P_DONE = 3'd2,
                         P_WIPE = 3'd3, P_WIPEDONE = 3'd4;
  logic [2:0] m_ps = P_RST;
  logic [7:0] m_cnt = 8'd0;
  initial m_done = 1'b0;
  always @(posedge clk) begin
    if (!painter_active) begin
      m_ps   <= P_RST;
      m_done <= 1'b0;
    end else begin
      case (m_ps)
        P_RST:
          if (painter_wipe) begin m_ps <= P_WIPE; m_cnt <= 8'd3; end
          else begin m_ps <= P_PAINT; m_cnt <= painter_num_triangles; end
        P_PAINT:
          if (m_cnt == 0) begin m_ps <= P_DONE; m_done <= 1'b1; end
          else m_cnt <= m_cnt - 8'd1;
        P_DONE:
          if (painter_wipe) begin m_ps <= P_WIPE; m_cnt <= 8'd3; m_done <= 1'b0; end
        P_WIPE:
          if (m_cnt == 0) begin m_ps <= P_WIPEDONE; m_done <= 1'b1; end
          else m_cnt <= m_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // Copy-out responder: one-cycle flush_done fl_delay cycles after flush_start
  int fl_delay;
  int fl_cnt = 0;
  initial fl_done = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      fl_cnt  <= 0;
      fl_done <= 1'b0;
    end else begin
      fl_done <= 1'b0;
      if (flush_start) fl_cnt <= fl_delay;
      else if (fl_cnt != 0) begin
        fl_cnt <= fl_cnt - 1;
        if (fl_cnt == 1) fl_done <= 1'b1;
      end
    end
  end

  // Monitor: records every copy-out request, wipe sequence and frame_done
  logic mon_en, mon_clr;
  logic [8:0] q_x[$];
  logic [7:0] q_y[$];
  logic [5:0] q_idx[$];
  logic [7:0] q_nt[$];
  int wipe_cnt, fd_cnt;
  logic wipe_prev;
  always @(negedge clk) begin
    if (mon_clr) begin
      q_x.delete(); q_y.delete(); q_idx.delete(); q_nt.delete();
      wipe_cnt = 0; fd_cnt = 0; wipe_prev = 1'b0;
    end else if (mon_en) begin
      if (flush_start) begin
        q_x.push_back(painter_x_offset);
        q_y.push_back(painter_y_offset);
        q_idx.push_back(tile_index);
        q_nt.push_back(painter_num_triangles);
      end
      if (painter_wipe && !wipe_prev) wipe_cnt++;
      wipe_prev = painter_wipe;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {28'd0, painter_active, painter_wipe, flush_start, busy, frame_done,
            painter_x_offset, painter_y_offset, tile_index, painter_num_triangles};
  endfunction

  typedef struct {
    logic       fs;
    logic [7:0] nt;
    logic       pd;
    logic       fd;
    logic [63:0] exp;
  } vec_t;

  function automatic vec_t mk(input int fs, nt, pd, fd, act, wp, fl, bs, fdn, x, y, idx, ent);
    vec_t v;
    v.fs = 1'(fs); v.nt = 8'(nt); v.pd = 1'(pd); v.fd = 1'(fd);
    v.exp = {28'd0, 1'(act), 1'(wp), 1'(fl), 1'(bs), 1'(fdn), 9'(x), 8'(y), 6'(idx), 8'(ent)};
    return v;
  endfunction

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int cyc = 0;
    while (fd_cnt == 0 && cyc < 20000) begin @(negedge clk); cyc++; end
    repeat (20) @(negedge clk);
    chk({name, "_frame_done_count"}, 64'(fd_cnt), 64'd1);
  endtask

  task automatic check_tiles(input string name, input logic [7:0] exp_nt);
    chk({name, "_flush_count"}, 64'(q_x.size()), 64'd64);
    if (q_x.size() == 64) begin
      int bad = 0;
      for (int i = 0; i < 64; i++) begin
        if (q_x[i] !== 9'((i % 16) * 20) || q_y[i] !== 8'((i / 16) * 45) ||
            q_idx[i] !== 6'(i) || q_nt[i] !== exp_nt) begin
          if (bad == 0)
            $display("FAIL %s_tile%0d: got x=%0d y=%0d idx=%0d nt=%0d required x=%0d y=%0d idx=%0d nt=%0d",
                     name, i, q_x[i], q_y[i], q_idx[i], q_nt[i], (i % 16) * 20, (i / 16) * 45, i, exp_nt);
          bad++;
        end
      end
      chk({name, "_tile_sequence_bad"}, 64'(bad), 64'd0);
    end
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = mk(0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0);
    vecs[1]  = mk(1, 37, 1, 0,  1, 1, 0, 1, 0,  0, 0, 0, 37);
    vecs[2]  = mk(0,  5, 1, 0,  1, 1, 0, 1, 0,  0, 0, 0, 37);
    vecs[3]  = mk(0,  5, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[4]  = mk(0,  5, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[5]  = mk(0,  5, 1, 0,  0, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[6]  = mk(0,  5, 1, 0,  0, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[7]  = mk(0,  5, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[8]  = mk(0,  5, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[9]  = mk(0,  5, 1, 0,  1, 0, 1, 1, 0,  0, 0, 0, 37);
    vecs[10] = mk(0,  5, 1, 1,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[11] = mk(0,  5, 1, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[12] = mk(0,  5, 1, 1,  1, 1, 0, 1, 0,  0, 0, 0, 37);
    vecs[13] = mk(0,  5, 1, 0,  1, 1, 0, 1, 0,  0, 0, 0, 37);
    vecs[14] = mk(0,  5, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[15] = mk(0,  5, 1, 0,  1, 0, 0, 1, 0,  0, 0, 0, 37);
    vecs[16] = mk(1,  5, 1, 0,  0, 0, 0, 1, 0, 20, 0, 1, 37);
    vecs[17] = mk(0,  5, 0, 0,  0, 0, 0, 1, 0, 20, 0, 1, 37);
    vecs[18] = mk(0,  5, 0, 0,  1, 0, 0, 1, 0, 20, 0, 1, 37);

    rst = 1'b1; frame_start = 1'b0; num_triangles = 8'd0;
    v_pd = 1'b0; v_fd = 1'b0; use_model = 1'b0; fl_delay = 3;
    mon_en = 1'b0; mon_clr = 1'b0;
    #1 chk("reset_outputs", outs(), 64'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // First tile cycle by cycle with hand-driven painter/flush handshakes
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      frame_start = vecs[i].fs; num_triangles = vecs[i].nt;
      v_pd = vecs[i].pd; v_fd = vecs[i].fd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Empty frame with the behavioural painter
    @(negedge clk); frame_start = 1'b0; rst = 1'b1;
    use_model = 1'b1; mon_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_mon();
    @(negedge clk); frame_start = 1'b1; num_triangles = 8'd0;
    @(negedge clk); frame_start = 1'b0;
    wait_frame_done("empty");
    check_tiles("empty", 8'd0);
    chk("empty_wipe_sequences", 64'(wipe_cnt), 64'd65);
    chk("empty_busy_after", {63'd0, busy}, 64'd0);

    // Count capture and busy rejection
    clear_mon();
    @(negedge clk); frame_start = 1'b1; num_triangles = 8'd37;
    @(negedge clk); frame_start = 1'b0; num_triangles = 8'd5;
    begin
      int cyc = 0;
      while (tile_index != 6'd10 && cyc < 20000) begin @(negedge clk); cyc++; end
      chk("reach_tile10", {63'd0, tile_index == 6'd10}, 64'd1);
    end
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("busy_reject_tile10", 64'(tile_index), 64'd10);
    wait_frame_done("capture");
    check_tiles("capture", 8'd37);

    // Flush stall on the first tile, then reset during PAINT of tile 20
    clear_mon();
    fl_delay = 500;
    @(negedge clk); frame_start = 1'b1; num_triangles = 8'd50;
    @(negedge clk); frame_start = 1'b0;
    begin
      int cyc = 0;
      int bad = 0;
      logic [8:0] x0;
      logic [7:0] y0;
      while (!flush_start && cyc < 500) begin @(negedge clk); cyc++; end
      chk("stall_flush_seen", {63'd0, flush_start}, 64'd1);
      x0 = painter_x_offset; y0 = painter_y_offset;
      @(posedge clk); #1 fl_delay = 3;
      cyc = 0;
      while (!fl_done && cyc < 600) begin
        if (painter_wipe || painter_x_offset != x0 || painter_y_offset != y0) bad++;
        @(posedge clk); #1 cyc++;
      end
      if (painter_wipe) bad++;
      chk("stall_flush_done_seen", {63'd0, fl_done}, 64'd1);
      chk("stall_held_bad_cycles", 64'(bad), 64'd0);
      @(posedge clk); #1;
      chk("stall_wipe_next_cycle", {63'd0, painter_wipe}, 64'd1);
    end
    begin
      int cyc = 0;
      while (!(tile_index == 6'd20 && m_ps == P_PAINT && painter_active) && cyc < 20000) begin
        @(negedge clk); cyc++;
      end
      chk("reach_tile20_paint", {63'd0, tile_index == 6'd20 && m_ps == P_PAINT}, 64'd1);
    end
    #2 rst = 1'b1;
    #1 chk("midpaint_reset_outputs", outs(), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_idle", {62'd0, painter_active, busy}, 64'd0);
    clear_mon();
    @(negedge clk); frame_start = 1'b1; num_triangles = 8'd0;
    @(posedge clk); #1;
    chk("restart_prewipe", {31'd0, painter_active, painter_wipe, busy,
                            painter_x_offset, painter_y_offset, tile_index},
        {31'd0, 1'b1, 1'b1, 1'b1, 9'd0, 8'd0, 6'd0});
    @(negedge clk); frame_start = 1'b0;
    wait_frame_done("restart");
    check_tiles("restart", 8'd0);
    chk("restart_wipe_sequences", 64'(wipe_cnt), 64'd65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
